apb_mem_slave: RTL

//  Parametrised APB slave with on-chip register-array memory. Successor to the fixed 8x64 combinational

---
 rtl/apb_mem_slave.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
//   APB slave backed by an on-chip register-array memory of DEPTH words.
//   PREADY, PSLVERR and PRDATA are all registered. Every access phase is
//   stretched by WAIT_CYCLES wait states. Writes honour PSTRB byte lanes.
//   An address outside 0..DEPTH-1 completes with PSLVERR=1 and has no effect
//   on memory.
//
// Ports
//   PCLK       clock; all state changes on the rising edge
//   PRESETn    asynchronous active-low reset
//   PSEL       slave select
//   PENABLE    access phase strobe
//   PWRITE     1 = write, 0 = read
//   PADDR      word address [ADDR_W-1:0]
//   PWDATA     write data [DATA_W-1:0]
//   PSTRB      write byte-lane enables [DATA_W/8-1:0]; ignored on reads
//   PRDATA     registered read data; holds its value until the next read completes
//   PREADY     registered transfer-complete flag, high for one cycle per transfer
//   PSLVERR    registered error flag, valid only while PREADY=1
//   state_dbg  current FSM state (0 = IDLE, 1 = WAIT, 2 = DONE)
//
// Handshake: the master holds a transfer "valid" from its setup cycle
// (PSEL=1, PENABLE=0) through its access cycles (PSEL=1, PENABLE=1). The
// slave signals "ready" by raising PREADY for one cycle, and the transfer
// completes in that cycle. If PSEL drops before PREADY, the transfer is
// abandoned and has no side effects.
// ---------------------------------------------------------------------------
module apb_mem_slave #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    output logic [1:0]          state_dbg
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that DEPTH == 2**ADDR_W still fits in the constant.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    addr_q;
    logic                write_q;
    logic                err_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [LANES-1:0]    strb_q;
    logic [3:0]          wait_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                in_range;
    logic [IDX_W-1:0]    paddr_idx;

    assign in_range  = ({1'b0, PADDR} < DEPTH_C);
    assign paddr_idx = PADDR[IDX_W-1:0];
    assign state_dbg = state;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= S_IDLE;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            PRDATA   <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            wait_cnt <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    // Only a proper setup cycle starts a transfer. PENABLE
                    // without a preceding setup is ignored.
                    if (PSEL && !PENABLE) begin
                        addr_q  <= paddr_idx;
                        write_q <= PWRITE;
                        err_q   <= !in_range;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
                        if (WAIT_CYCLES == 0) begin
                            state   <= S_DONE;
                            PREADY  <= 1'b1;
                            PSLVERR <= !in_range;
                            if (!PWRITE) begin
                                PRDATA <= in_range ? mem[paddr_idx] : '0;
                            end
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES);
                        end
                    end
                end

                S_WAIT: begin
                    if (!PSEL) begin
                        // Master abandoned the transfer; nothing is committed.
                        state <= S_IDLE;
                    end else if (PENABLE) begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            state   <= S_DONE;
                            PREADY  <= 1'b1;
                            PSLVERR <= err_q;
                            if (!write_q) begin
                                PRDATA <= err_q ? '0 : mem[addr_q];
                            end
                        end
                    end
                end

                S_DONE: begin
                    state   <= S_IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    // The write commits at the edge that ends the completing cycle.
                    if (write_q && !err_q) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (strb_q[i]) begin
                                mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
                            end
                        end
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                end
            endcase
        end
    end

endmodule
